// File: rtl/aes_pkg.sv
// Shared types and constants for the AES host driver and its result FIFO.
package aes_pkg;

  localparam logic AES_ENC = 1'b0;
  localparam logic AES_DEC = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } drv_state_t;

  // Result FIFO entry layout: {err, mode, text}.
  typedef struct packed {
    logic         err;
    logic         mode;
    logic [127:0] text;
  } res_entry_t;

  localparam int unsigned ResWidth = $bits(res_entry_t);

endpackage

// File: rtl/aes_result_fifo.sv
// Small power-of-2 result FIFO; head is presented combinationally from storage.
module aes_result_fifo #(
  parameter int unsigned WIDTH = 130,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PtrW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]             count_q, count_d;
  logic                        pop_eff;

  // Popping an empty FIFO is a no-op.
  assign pop_eff = pop_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    unique case ({push_i, pop_eff})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop_eff) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/aes_host_driver.sv
// Initiator for the AES core START/DONE handshake; one job in flight, results queued so
// that a DONE pulse from the non-stallable core is never lost.
module aes_host_driver
  import aes_pkg::*;
#(
  parameter int unsigned RES_DEPTH   = 2,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [127:0] in_key,
  input  logic [127:0] in_text,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_mode,
  output logic [127:0] out_text,
  output logic         out_err,
  output logic         busy,
  output logic         spurious,
  output logic         aes_start,
  output logic         aes_encdec,
  output logic [127:0] aes_key,
  output logic [127:0] aes_text,
  input  logic         aes_done,
  input  logic [127:0] aes_textout
);

  localparam int unsigned     CntW    = $clog2(RES_DEPTH) + 1;
  localparam int unsigned     TmrW    = $clog2(TIMEOUT_CYC);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYC - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(RES_DEPTH);

  drv_state_t      state_q, state_d;
  logic [TmrW-1:0] timer_q;
  logic            mode_q, start_q, in_ready_q, spurious_q;
  logic [127:0]    key_q, text_q;

  logic            accept, push, pop_eff;
  res_entry_t      push_entry, head;
  logic [CntW-1:0] cnt_q, cnt_next;

  assign accept   = in_valid && in_ready_q;
  assign pop_eff  = out_ready && (cnt_q != '0);
  assign cnt_next = cnt_q + CntW'(push) - CntW'(pop_eff);

  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    push_entry = '0;
    unique case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait: begin
        // DONE takes priority over a coincident timeout.
        if (aes_done) begin
          push            = 1'b1;
          push_entry.mode = mode_q;
          push_entry.text = aes_textout;
          state_d         = StIdle;
        end else if (timer_q == TmrLast) begin
          push            = 1'b1;
          push_entry.err  = 1'b1;
          push_entry.mode = mode_q;
          state_d         = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      mode_q     <= 1'b0;
      key_q      <= '0;
      text_q     <= '0;
      start_q    <= 1'b0;
      in_ready_q <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= accept;
      // Space is reserved at accept: only offer a job when a result slot is guaranteed.
      in_ready_q <= (state_d == StIdle) && (cnt_next < CntFull);
      if (accept) begin
        mode_q <= in_mode;
        key_q  <= in_key;
        text_q <= in_text;
      end
      if (state_q == StIssue) begin
        timer_q <= '0;
      end else if (state_q == StWait) begin
        timer_q <= timer_q + TmrW'(1);
      end
      if (aes_done && (state_q != StWait)) begin
        spurious_q <= 1'b1;
      end
    end
  end

  aes_result_fifo #(
    .WIDTH (ResWidth),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk_i   (CLK),
    .rst_ni  (nRST),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (out_ready),
    .count_o (cnt_q),
    .head_o  (head)
  );

  assign in_ready   = in_ready_q;
  assign busy       = (state_q != StIdle);
  assign spurious   = spurious_q;
  assign aes_start  = start_q;
  assign aes_encdec = mode_q;
  assign aes_key    = key_q;
  assign aes_text   = text_q;
  assign out_valid  = (cnt_q != '0);
  assign out_mode   = head.mode;
  assign out_text   = head.text;
  assign out_err    = head.err;

endmodule
